// File: rtl/ex_mul_div_unit_pkg.sv
// Shared types for the RV64M iterative multiply/divide unit.
// funct3 encodings, FSM states and operand-signedness helpers.
package ex_mul_div_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } md_state_e;

  function automatic logic sgn_a(input md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic sgn_b(input md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_mul_div_unit_if.sv
// ID/EX-to-mul/div bundle plus pipeline controller hold/flush
// and the result/stall return path.
interface ex_mul_div_unit_if #(
  parameter int XLEN = 64
);
  logic            valid_i;
  logic [2:0]      op_i;
  logic            word_i;
  logic [XLEN-1:0] src1_i;
  logic [XLEN-1:0] src2_i;
  logic            hold_i;
  logic            flush_i;
  logic            stall_req_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, op_i, word_i, src1_i, src2_i,
    output hold_i, flush_i,
    input  stall_req_o, done_o, result_o
  );

  modport slave (
    input  valid_i, op_i, word_i, src1_i, src2_i,
    input  hold_i, flush_i,
    output stall_req_o, done_o, result_o
  );
endinterface

// File: rtl/mdu_divider.sv
// Restoring divider datapath: one quotient bit per step.
// W ops pre-shift the dividend so 32 steps suffice.
module mdu_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);
  localparam int HW = XLEN / 2;

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   part;
  logic            ge;

  always_comb begin
    part    = {rem_q, quo_q[XLEN-1]};
    ge      = part >= {1'b0, dvs_q};
    rem_nxt = ge ? XLEN'(part - {1'b0, dvs_q})
                 : part[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= word ? {dividend[HW-1:0], {HW{1'b0}}}
                    : dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end
endmodule

// File: rtl/ex_mul_div_unit.sv
// Iterative RV64M mul/div in EX: stalls the pipe while busy,
// holds the result in DONE until EX/MEM captures it.
module ex_mul_div_unit
  import ex_mul_div_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic              clk,
  input logic              rst,
  ex_mul_div_unit_if.slave md
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN) + 1;

  md_state_e         state_q, state_d;
  md_op_e            op, op_q;
  logic              word_q, neg_q, neg_d;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   a_abs_q, res_q;
  logic [2*XLEN-1:0] prod_q, prod_nxt, pfull, psig;
  logic [XLEN:0]     psum;
  logic [XLEN-1:0]   ea, eb, ua, ub, minv;
  logic [XLEN-1:0]   quo_nxt, rem_nxt, dsel, dsig;
  logic [XLEN-1:0]   raw, fin, spec_raw, spec_res;
  logic              sa, sb, is_div, is_rem;
  logic              dz, ovf, special, start, run;

  // Operand extension, magnitude and special-case detection
  always_comb begin
    op     = md_op_e'(md.op_i);
    is_div = op[2];
    is_rem = op[2] & op[1];
    ea = md.src1_i;
    eb = md.src2_i;
    if (md.word_i) begin
      ea = sgn_a(op) ? {{HW{md.src1_i[HW-1]}}, md.src1_i[HW-1:0]}
                     : {{HW{1'b0}}, md.src1_i[HW-1:0]};
      eb = sgn_b(op) ? {{HW{md.src2_i[HW-1]}}, md.src2_i[HW-1:0]}
                     : {{HW{1'b0}}, md.src2_i[HW-1:0]};
    end
    sa    = sgn_a(op) & ea[XLEN-1];
    sb    = sgn_b(op) & eb[XLEN-1];
    ua    = sa ? -ea : ea;
    ub    = sb ? -eb : eb;
    neg_d = sa ^ (sb & ~is_rem);
    minv  = md.word_i ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}}
                      : {1'b1, {(XLEN-1){1'b0}}};
    dz    = eb == '0;
    ovf   = sgn_b(op) & (ea == minv) & (eb == '1);
    special  = is_div & (dz | ovf);
    spec_raw = is_rem ? (dz ? ea : '0) : (dz ? '1 : ea);
    spec_res = md.word_i
             ? {{HW{spec_raw[HW-1]}}, spec_raw[HW-1:0]}
             : spec_raw;
  end

  assign start = (state_q == S_IDLE) & md.valid_i & ~md.flush_i;
  assign run   = (state_q == S_CALC) & md.valid_i & ~md.flush_i;

  // Shift-add step and final sign fix-up on the last step's values
  always_comb begin
    psum = {1'b0, prod_q[2*XLEN-1:XLEN]}
         + (prod_q[0] ? {1'b0, a_abs_q} : '0);
    prod_nxt = {psum, prod_q[XLEN-1:1]};
    pfull = word_q ? {{XLEN{1'b0}}, prod_nxt[XLEN+HW-1:HW]}
                   : prod_nxt;
    psig = neg_q ? -pfull : pfull;
    dsel = op_q[1] ? rem_nxt : quo_nxt;
    dsig = neg_q ? -dsel : dsel;
    raw  = '0;
    unique case (1'b1)
      op_q[2]:         raw = dsig;
      op_q == OP_MUL:  raw = psig[XLEN-1:0];
      default:         raw = psig[2*XLEN-1:XLEN];
    endcase
    fin = word_q ? {{HW{raw[HW-1]}}, raw[HW-1:0]} : raw;
  end

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .step     (run),
    .word     (md.word_i),
    .dividend (ua),
    .divisor  (ub),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = special ? S_DONE : S_CALC;
      S_CALC: begin
        if (!run)            state_d = S_IDLE;
        else if (cnt_q == 1) state_d = S_DONE;
      end
      S_DONE: if (md.flush_i || !md.hold_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= OP_MUL;
      word_q  <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      a_abs_q <= '0;
      prod_q  <= '0;
      res_q   <= '0;
    end else if (start) begin
      op_q    <= op;
      word_q  <= md.word_i;
      neg_q   <= neg_d;
      cnt_q   <= md.word_i ? CW'(HW) : CW'(XLEN);
      a_abs_q <= ua;
      prod_q  <= {{XLEN{1'b0}}, ub};
      if (special) res_q <= spec_res;
    end else if (run) begin
      prod_q <= prod_nxt;
      cnt_q  <= cnt_q - 1'b1;
      if (cnt_q == 1) res_q <= fin;
    end
  end

  // Stall request is gated by reset so every output is quiet in reset
  always_comb begin
    md.stall_req_o = rst & md.valid_i & ~md.flush_i
                   & (state_q != S_DONE);
    md.done_o      = state_q == S_DONE;
    md.result_o    = res_q;
  end
endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Directed bench for ex_mul_div_unit: latency, results,
// hold, flush and asynchronous reset behaviour.
module tb_ex_mul_div_unit;
  import ex_mul_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  ex_mul_div_unit_if #(.XLEN(64)) md();

  ex_mul_div_unit #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat,
                        input string nm);
    int cyc = 0;
    bit stall_bad = 0;
    md.valid_i = 1; md.op_i = op; md.word_i = w;
    md.src1_i = a; md.src2_i = b;
    md.hold_i = 0; md.flush_i = 0;
    #1;
    while (!md.done_o && cyc < 200) begin
      if (md.stall_req_o !== 1'b1) stall_bad = 1;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != lat) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d", nm, cyc, lat);
    end
    checks++;
    if (md.result_o !== exp) begin
      errors++;
      $display("FAIL %s result got %h exp %h", nm, md.result_o, exp);
    end
    checks++;
    if (stall_bad || md.stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s stall got bad=%0d done_stall=%b exp 0/0",
               nm, stall_bad, md.stall_req_o);
    end
    md.valid_i = 0;
    @(posedge clk); #1;
    checks++;
    if (md.done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s done_clear got %b exp 0", nm, md.done_o);
    end
  endtask

  task automatic test_reset();
    md.valid_i = 1; md.op_i = OP_MUL; md.word_i = 0;
    md.src1_i = 3; md.src2_i = 4; md.hold_i = 0; md.flush_i = 0;
    rst = 0;
    #1;
    checks++;
    if (md.stall_req_o !== 0 || md.done_o !== 0 || md.result_o !== 0) begin
      errors++;
      $display("FAIL reset outs got %b %b %h exp 0 0 0",
               md.stall_req_o, md.done_o, md.result_o);
    end
    repeat (2) @(posedge clk);
    #1;
    md.valid_i = 0;
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if (md.done_o !== 0 || md.stall_req_o !== 0) begin
      errors++;
      $display("FAIL post_reset got done=%b stall=%b exp 0 0",
               md.done_o, md.stall_req_o);
    end
  endtask

  task automatic test_mul();
    run_op(OP_MUL, 0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul");
    run_op(OP_MULHU, 0, '1, 64'd2, 64'd1, 65, "mulhu");
    run_op(OP_MULHSU, 0, '1, 64'd2, '1, 65, "mulhsu");
    run_op(OP_MULH, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 65, "mulh");
    run_op(OP_MUL, 1, 64'h7FFF_FFFF, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw");
  endtask

  task automatic test_div_special();
    run_op(OP_DIV, 0, 64'h8000_0000_0000_0000, '1,
           64'h8000_0000_0000_0000, 1, "div_ovf");
    run_op(OP_REM, 0, 64'h8765_4321_0FED_CBA9, 64'd0,
           64'h8765_4321_0FED_CBA9, 1, "rem_by0");
    run_op(OP_DIVU, 0, 64'd5, 64'd0, '1, 1, "divu_by0");
  endtask

  task automatic test_div();
    run_op(OP_DIV, 0, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div");
    run_op(OP_REM, 0, 64'd100, -64'sd7, 64'd2, 65, "rem");
    run_op(OP_DIVU, 0, '1, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 65, "divu");
    run_op(OP_DIV, 1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw");
    run_op(OP_REM, 1, -64'sd7, 64'd2, '1, 33, "remw");
  endtask

  task automatic test_hold();
    int cyc = 0;
    md.valid_i = 1; md.op_i = OP_MUL; md.word_i = 0;
    md.src1_i = 3; md.src2_i = 5; md.hold_i = 1; md.flush_i = 0;
    #1;
    while (!md.done_o && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 65) begin
      errors++;
      $display("FAIL hold latency got %0d exp 65", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (md.done_o !== 1'b1 || md.result_o !== 64'd15) begin
        errors++;
        $display("FAIL hold_%0d got done=%b res=%h exp 1 15",
                 i, md.done_o, md.result_o);
      end
      if (i == 3) begin
        md.hold_i = 0;
        md.valid_i = 0;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (md.done_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got done=%b exp 0", md.done_o);
    end
  endtask

  task automatic test_flush();
    md.valid_i = 1; md.op_i = OP_DIV; md.word_i = 0;
    md.src1_i = 100; md.src2_i = 7; md.hold_i = 0; md.flush_i = 0;
    repeat (20) @(posedge clk);
    #1;
    md.flush_i = 1;
    #1;
    checks++;
    if (md.stall_req_o !== 1'b0 || md.done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle got stall=%b done=%b exp 0 0",
               md.stall_req_o, md.done_o);
    end
    @(posedge clk); #1;
    md.flush_i = 0;
    // A restart here only takes a full 65 cycles if the flush reached IDLE
    run_op(OP_DIV, 0, 64'd100, 64'd7, 64'd14, 65, "after_flush");
  endtask

  task automatic test_rst_mid_calc();
    md.valid_i = 1; md.op_i = OP_MUL; md.word_i = 0;
    md.src1_i = 7; md.src2_i = 9; md.hold_i = 0; md.flush_i = 0;
    repeat (10) @(posedge clk);
    #3;
    rst = 0;
    #1;
    checks++;
    if (md.stall_req_o !== 0 || md.done_o !== 0 || md.result_o !== 0) begin
      errors++;
      $display("FAIL rst_mid got %b %b %h exp 0 0 0",
               md.stall_req_o, md.done_o, md.result_o);
    end
    md.valid_i = 0;
    #1;
    rst = 1;
    @(posedge clk); #1;
    run_op(OP_MUL, 0, 64'd7, 64'd9, 64'd63, 65, "after_rst");
  endtask

  task automatic test_back_to_back();
    run_op(OP_REMU, 0, 64'd1000, 64'd33, 64'd10, 65, "b2b_remu");
    run_op(OP_DIVU, 1, 64'hFFFF_FFFF_8000_0005, 64'd16,
           64'd134217728, 33, "b2b_divuw");
  endtask

  initial begin
    md.valid_i = 0; md.op_i = '0; md.word_i = 0;
    md.src1_i = '0; md.src2_i = '0; md.hold_i = 0; md.flush_i = 0;
    test_reset();
    test_mul();
    test_div_special();
    test_div();
    test_hold();
    test_flush();
    test_rst_mid_calc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mul_div_unit.md
# ex_mul_div_unit

Iterative RV64M multiply/divide unit in the EX stage. It accepts one M-extension operation from the ID/EX register and holds the pipeline by asserting the mul/div stall request into the pipeline controller while it computes. It returns the 64-bit result to the EX result mux for the EX/MEM register. It releases the pipeline only once the result has been consumed.

## Interface
Parameters:
- XLEN, 64, datapath width; W-variants operate on the low 32 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  ID/EX holds an M-extension instruction.
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- word_i  in  1  W-variant (MULW/DIVW/DIVUW/REMW/REMUW).
- src1_i, src2_i  in  XLEN  operands; stable while ID/EX is stalled.
- hold_i  in  1  ID/EX stall bit (stall_o[3]) from the pipeline controller; the same instruction remains in ID/EX next cycle.
- flush_i  in  1  ID/EX flush bit (flush_o[3]); abort.
- stall_req_o  out  1  to the controller's alu_mul_div_valid_ex_i.
- done_o  out  1  result_o is valid this cycle.
- result_o  out  XLEN  final result.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state: IDLE, with result_o=0, done_o=0, stall_req_o=0.
- IDLE:
  - If valid_i & ~flush_i: latch |operands| (or low 32 bits for W, sign- or zero-extended per op), the result sign, op, and word. Load counter = 64 (32 for W). Go to CALC.
- Special cases bypass CALC and load the result directly, then go to DONE:
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / −1, per effective width): quotient = dividend; remainder = 0.
- CALC, multiply: radix-2 shift-add on |a|×|b| into a 2×XLEN product register, one bit per cycle.
- CALC, divide: restoring divide, one quotient bit per cycle.
- Counter decrements each cycle; at 1, go to DONE.
- Entering DONE:
  - Apply sign fix-up (two's complement) and select the output: low half (MUL), high half (MULH*), quotient, or remainder.
  - W: sign-extend bit 31 to XLEN.
  - Sign rules: MULHSU treats src2 as unsigned. The REM sign follows the dividend. The DIV sign is the XOR of the operand signs.
- DONE: done_o=1. If hold_i=0, go to IDLE (result captured by EX/MEM this edge). Otherwise stay in DONE and hold result_o.
- stall_req_o = valid_i & ~flush_i & (state != DONE). It is combinational and therefore asserted in the IDLE cycle the op arrives.
- flush_i in any state: next state IDLE, done_o low next cycle, no result produced.
- valid_i dropping in CALC (should not occur): abort to IDLE.

## Timing
- Latency, 64-bit op: valid_i first seen at cycle 0; CALC during cycles 1–64; DONE with done_o=1 at cycle 65. stall_req_o is high during cycles 0–64 and low at cycle 65.
- Latency, W ops: DONE at cycle 33.
- Latency, special cases: DONE at cycle 1.
- Back-to-back ops: the next op can start in the cycle after DONE→IDLE. There is no internal queue.
- Reset mid-CALC returns to IDLE immediately and clears all outputs.
- Simultaneous flush_i and DONE: flush wins; the state goes to IDLE.

## Structure
- Opcode encodings for funct3 and the W flag belong in sysconfig.v, beside the existing pipeline stall/flush constants.
- Sub-module mdu_divider holds the restoring divider datapath (remainder/quotient registers and step logic). The multiplier, sign handling and FSM stay in the top module.

## Test plan
- MUL 7×(−3), 64-bit → stall_req_o high for cycles 0–64; result_o=0xFFFF_FFFF_FFFF_FFEB at cycle 65; done_o for 1 cycle with hold_i=0.
- MULHU 0xFFFF_FFFF_FFFF_FFFF×2 → result_o=1. MULHSU −1×2 → all ones.
- DIV: 0x8000_0000_0000_0000 / −1 → quotient 0x8000_0000_0000_0000 at cycle 1. REM x/0 → x. DIVU 5/0 → all ones.
- DIVW −7/2 → 0xFFFF_FFFF_FFFF_FFFD at cycle 33. REMW → 0xFFFF_FFFF_FFFF_FFFF.
- hold_i high for 3 cycles in DONE → result_o stable and done_o held; returns to IDLE on the first cycle with hold_i=0.
- Abort cases:
  - flush_i pulse at cycle 20 of a DIV → stall_req_o low that cycle; state IDLE next cycle; no done_o.
  - rst asserted mid-CALC → all outputs 0 asynchronously.
